stream_demux_nbit: RTL and testbench

Registered 1-to-CH stream demultiplexer with valid/ready handshake: routes N-bit beats from one input stream to one of CH output channels, each fronted by a one-entry output register. Optional packet mode locks routing for a whole packet. Out-of-range selects are consumed and counted. Sits between a single producer and several per-lane consumers, in place of the plain combinational demux wherever flow control or timing isolation is needed.

---
 rtl/stream_demux_nbit.sv | 115 +++++++++++
 tb/tb_stream_demux_nbit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_nbit.sv
// Registered 1-to-CH stream demultiplexer with valid/ready handshake.
// Each lane has a one-entry output register; optional packet-locked routing.
module stream_demux_nbit #(
  parameter int unsigned N        = 8,
  parameter int unsigned CH       = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned PKT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic [CH-1:0]     out_valid,
  input  logic [CH-1:0]     out_ready,
  output logic [CH*N-1:0]   out_data,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int unsigned DW    = CH * N;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lk_q, lk_d;
  logic [CH-1:0]      valid_q, valid_d;
  logic [DW-1:0]      data_q, data_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               sel_ready;
  logic               accept;
  logic [CH-1:0]      wr;

  // Target resolution and handshake; only the targeted lane gates in_ready.
  always_comb begin
    tgt       = (state_q == S_LOCKED) ? lk_q : in_sel;
    tgt_ok    = (32'(tgt) < CH);
    sel_ready = 1'b0;
    for (int k = 0; k < int'(CH); k++) begin
      if (tgt == SEL_W'(k)) sel_ready = ~valid_q[k] | out_ready[k];
    end
    in_ready = tgt_ok ? sel_ready : 1'b1;
    accept   = in_valid & in_ready;
    wr       = '0;
    for (int k = 0; k < int'(CH); k++) begin
      wr[k] = accept & (tgt == SEL_W'(k));
    end
  end

  // Next-state: lane registers, drop counter, packet lock.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    state_d = state_q;
    lk_d    = lk_q;

    for (int k = 0; k < int'(CH); k++) begin
      if (wr[k]) begin
        valid_d[k]        = 1'b1;
        data_d[k*N +: N]  = in_data;
      end else if (valid_q[k] & out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    if (accept && !tgt_ok && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if ((PKT_MODE != 0) && accept) begin
      case (state_q)
        S_IDLE: begin
          if (!in_last) begin
            state_d = S_LOCKED;
            lk_d    = in_sel;
          end
        end
        S_LOCKED: begin
          if (in_last) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lk_q    <= '0;
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q == S_LOCKED);

endmodule

// File: tb/tb_stream_demux_nbit.sv
// Bench for stream_demux_nbit: instance 0 is CH=4 per-beat routing,
// instance 1 is CH=3 packet mode; both are tracked by a lane-level reference model.
module tb_stream_demux_nbit;

  logic clk;
  logic rst_n;

  logic       iv_s [2];
  logic [7:0] id_s [2];
  logic [1:0] is_s [2];
  logic       il_s [2];

  logic        a_ir, a_busy;
  logic [3:0]  a_or, a_ov;
  logic [31:0] a_od;
  logic [15:0] a_dc;

  logic        b_ir, b_busy;
  logic [2:0]  b_or, b_ov;
  logic [23:0] b_od;
  logic [15:0] b_dc;

  int checks = 0;
  int errors = 0;

  // Reference model state: one holding slot per lane, lock flag, drop tally.
  bit       mv    [2][4];
  bit [7:0] md    [2][4];
  bit       mlock [2];
  int       mlk   [2];
  int       mdrop [2];
  bit       macc  [2];
  int       chn   [2] = '{4, 3};
  bit       pkt   [2] = '{1'b0, 1'b1};

  stream_demux_nbit #(.N(8), .CH(4), .SEL_W(2), .PKT_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s[0]), .in_ready(a_ir),
    .in_data(id_s[0]), .in_sel(is_s[0]), .in_last(il_s[0]),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .drop_cnt(a_dc), .busy(a_busy)
  );

  stream_demux_nbit #(.N(8), .CH(3), .SEL_W(2), .PKT_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s[1]), .in_ready(b_ir),
    .in_data(id_s[1]), .in_sel(is_s[1]), .in_last(il_s[1]),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .drop_cnt(b_dc), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit get_or(input int i, input int k);
    return (i == 0) ? a_or[k] : b_or[k];
  endfunction

  function automatic int tgt_of(input int i);
    return (pkt[i] && mlock[i]) ? mlk[i] : int'(is_s[i]);
  endfunction

  function automatic bit exp_ready(input int i);
    int t = tgt_of(i);
    if (t >= chn[i]) return 1'b1;
    return !mv[i][t] || get_or(i, t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin mv[i][k] = 0; md[i][k] = 0; end
      mlock[i] = 0; mlk[i] = 0; mdrop[i] = 0; macc[i] = 0;
    end
  endtask

  // Apply the rules for one clock edge with the inputs present before it.
  task automatic model_edge(input int i);
    int t   = tgt_of(i);
    bit acc = iv_s[i] && exp_ready(i);
    for (int k = 0; k < chn[i]; k++) begin
      if (acc && t == k) begin
        mv[i][k] = 1; md[i][k] = id_s[i];
      end else if (mv[i][k] && get_or(i, k)) begin
        mv[i][k] = 0;
      end
    end
    if (acc && t >= chn[i] && mdrop[i] < 65535) mdrop[i]++;
    if (pkt[i] && acc) begin
      if (!mlock[i] && !il_s[i]) begin mlock[i] = 1; mlk[i] = int'(is_s[i]); end
      else if (mlock[i] && il_s[i]) mlock[i] = 0;
    end
    macc[i] = acc;
  endtask

  task automatic compare_all(input int i);
    logic [3:0]  ov;
    logic [31:0] od;
    logic        ir, bz;
    logic [15:0] dc;
    if (i == 0) begin ov = a_ov; od = a_od; ir = a_ir; bz = a_busy; dc = a_dc; end
    else begin ov = {1'b0, b_ov}; od = {8'h00, b_od}; ir = b_ir; bz = b_busy; dc = b_dc; end
    chk($sformatf("u%0d.in_ready", i), 32'(ir), 32'(exp_ready(i)));
    chk($sformatf("u%0d.busy", i), 32'(bz), 32'(mlock[i]));
    chk($sformatf("u%0d.drop_cnt", i), 32'(dc), 32'(mdrop[i]));
    for (int k = 0; k < chn[i]; k++) begin
      chk($sformatf("u%0d.out_valid[%0d]", i, k), 32'(ov[k]), 32'(mv[i][k]));
      if (mv[i][k]) chk($sformatf("u%0d.out_data[%0d]", i, k), 32'(od[k*8 +: 8]), 32'(md[i][k]));
    end
  endtask

  // One clock: compare mid-cycle, then advance the model across the edge.
  task automatic cyc();
    #2;
    compare_all(0);
    compare_all(1);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin iv_s[i] = 0; id_s[i] = 0; is_s[i] = 0; il_s[i] = 0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst.a_out_valid", 32'(a_ov), 32'h0);
    chk("rst.b_out_valid", 32'(b_ov), 32'h0);
    chk("rst.a_out_data", a_od, 32'h0);
    chk("rst.b_out_data", 32'(b_od), 32'h0);
    chk("rst.drop_cnt", 32'({a_dc, b_dc}), 32'h0);
    chk("rst.busy", 32'({a_busy, b_busy}), 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int i, input logic [1:0] sel, input logic [7:0] d, input logic last);
    iv_s[i] = 1'b1; is_s[i] = sel; id_s[i] = d; il_s[i] = last;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    int         exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    rst_n = 1'b1;
    a_or = 4'hF; b_or = 3'h7;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Back-to-back beats to each lane with all consumers ready.
    vecs[0] = '{sel: 2'd0, data: 8'h0F, exp_ch: 0, exp_data: 8'h0F};
    vecs[1] = '{sel: 2'd1, data: 8'h2F, exp_ch: 1, exp_data: 8'h2F};
    vecs[2] = '{sel: 2'd2, data: 8'h1F, exp_ch: 2, exp_data: 8'h1F};
    vecs[3] = '{sel: 2'd3, data: 8'h4F, exp_ch: 3, exp_data: 8'h4F};
    for (int j = 0; j < 4; j++) begin
      send(0, vecs[j].sel, vecs[j].data, 1'b0);
      #1;
      chk($sformatf("t1.in_ready[%0d]", j), 32'(a_ir), 32'h1);
      cyc();
      chk($sformatf("t1.valid[%0d]", j), 32'(a_ov[vecs[j].exp_ch]), 32'h1);
      chk($sformatf("t1.data[%0d]", j), 32'(a_od[vecs[j].exp_ch*8 +: 8]), 32'(vecs[j].exp_data));
    end
    chk("t1.drop_cnt", 32'(a_dc), 32'h0);
    iv_s[0] = 0;
    cyc();

    // Backpressure on lane 1 while lane 2 keeps flowing.
    a_or = 4'b1101;
    send(0, 2'd1, 8'hAA, 1'b0); cyc();
    send(0, 2'd2, 8'hCC, 1'b0); #1;
    chk("bp.ready_ch2", 32'(a_ir), 32'h1);
    cyc();
    chk("bp.ch2_data", 32'(a_od[23:16]), 32'hCC);
    send(0, 2'd1, 8'hBB, 1'b0); #1;
    chk("bp.ready_bb", 32'(a_ir), 32'h0);
    cyc(); cyc();
    chk("bp.ch1_hold", 32'(a_od[15:8]), 32'hAA);
    chk("bp.ch1_valid", 32'(a_ov[1]), 32'h1);
    a_or = 4'hF; #1;
    chk("bp.ready_release", 32'(a_ir), 32'h1);
    cyc();
    chk("bp.ch1_bb", 32'(a_od[15:8]), 32'hBB);
    chk("bp.ch1_valid2", 32'(a_ov[1]), 32'h1);
    iv_s[0] = 0;
    cyc();

    // Out-of-range select on the CH=3 instance: consumed and counted.
    do_reset();
    send(1, 2'd3, 8'h55, 1'b1);
    for (int j = 0; j < 5; j++) cyc();
    chk("drop.cnt5", 32'(b_dc), 32'd5);
    chk("drop.no_valid", 32'(b_ov), 32'h0);
    for (int j = 0; j < 65535; j++) cyc();
    chk("drop.sat", 32'(b_dc), 32'hFFFF);
    iv_s[1] = 0;
    cyc();

    // Packet lock: whole packet follows the first beat's select.
    do_reset();
    send(1, 2'd2, 8'h11, 1'b0); cyc();
    chk("pkt.busy1", 32'(b_busy), 32'h1);
    chk("pkt.b1", 32'(b_od[23:16]), 32'h11);
    send(1, 2'd0, 8'h22, 1'b0); cyc();
    chk("pkt.busy2", 32'(b_busy), 32'h1);
    chk("pkt.b2", 32'(b_od[23:16]), 32'h22);
    send(1, 2'd1, 8'h33, 1'b1); cyc();
    chk("pkt.busy3", 32'(b_busy), 32'h0);
    chk("pkt.b3", 32'(b_od[23:16]), 32'h33);
    chk("pkt.ch01_idle", 32'(b_ov[1:0]), 32'h0);
    send(1, 2'd0, 8'h44, 1'b1); cyc();
    chk("pkt.next_ch0", 32'(b_od[7:0]), 32'h44);
    chk("pkt.next_v0", 32'(b_ov[0]), 32'h1);
    iv_s[1] = 0;
    cyc();

    // Asynchronous reset while locked with lane 2 full.
    send(1, 2'd3, 8'h66, 1'b1); cyc();
    b_or = 3'b000;
    send(1, 2'd2, 8'h77, 1'b0); cyc();
    send(1, 2'd0, 8'h78, 1'b0); cyc();
    chk("mid.busy_pre", 32'(b_busy), 32'h1);
    chk("mid.ch2_full", 32'(b_ov[2]), 32'h1);
    chk("mid.drop_pre", 32'(b_dc), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid.valid0", 32'(b_ov), 32'h0);
    chk("mid.busy0", 32'(b_busy), 32'h0);
    chk("mid.drop0", 32'(b_dc), 32'h0);
    idle_inputs();
    model_reset();
    b_or = 3'h7;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send(1, 2'd1, 8'h99, 1'b1); cyc();
    chk("mid.after_ch1", 32'(b_od[15:8]), 32'h99);
    chk("mid.after_v1", 32'(b_ov), 32'h2);
    iv_s[1] = 0;
    cyc();

    // Randomised traffic on both instances against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(iv_s[i] && !macc[i])) begin
          iv_s[i] = ($urandom_range(0, 9) < 7);
          id_s[i] = 8'($urandom);
          is_s[i] = 2'($urandom_range(0, 3));
          il_s[i] = ($urandom_range(0, 9) < 3);
        end
      end
      a_or = 4'($urandom);
      b_or = 3'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
